// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO family (single-clock and dual-clock variants).
package fifo_pkg;

  localparam int FIFO_STD  = 0;
  localparam int FIFO_FWFT = 1;

  function automatic int ptr_w(input int d);
    return $clog2(d);
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port storage: synchronous write, asynchronous read. Contents are not reset.
module fifo_mem
  import fifo_pkg::*;
#(
  parameter int width = 8,
  parameter int depth = 8,
  localparam int AW = ptr_w(depth)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [AW-1:0]    waddr_i,
  input  logic [width-1:0] wdata_i,
  input  logic [AW-1:0]    raddr_i,
  output logic [width-1:0] rdata_o
);

  logic [width-1:0] mem_q [depth];

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fifo_sync_prog.sv
// Single-clock FIFO with selectable standard/FWFT read, occupancy count,
// runtime almost-full/almost-empty thresholds, sticky error flags and flush.
module fifo_sync_prog
  import fifo_pkg::*;
#(
  parameter int width = 8,
  parameter int depth = 8,
  parameter int fwft  = FIFO_STD,
  localparam int AW = ptr_w(depth)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             wr,
  input  logic [width-1:0] data_in,
  input  logic             rd,
  output logic [width-1:0] data_out,
  input  logic [AW:0]      af_thresh,
  input  logic [AW:0]      ae_thresh,
  input  logic             clr_err,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [AW:0]      count,
  output logic             overflow,
  output logic             underflow
);

  localparam logic [AW:0] DEPTH_C = (AW+1)'(depth);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             wr_acc, rd_acc;
  logic [width-1:0] rdata;

  // Handshake: a write is taken on any edge where wr=1 and full=0, a read
  // where rd=1 and empty=0, both judged on pre-edge flags; flush discards both.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= af_thresh);
  assign almost_empty = (count_q <= ae_thresh);
  assign count        = count_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

  assign wr_acc = wr & ~full  & ~flush;
  assign rd_acc = rd & ~empty & ~flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_acc) wr_ptr_d = wr_ptr_q + 1'b1;
      if (rd_acc) rd_ptr_d = rd_ptr_q + 1'b1;
      case ({wr_acc, rd_acc})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // A new error event in the same cycle as clr_err keeps the flag set.
  always_comb begin
    ovf_d = (ovf_q & ~clr_err) | (wr & full  & ~flush);
    unf_d = (unf_q & ~clr_err) | (rd & empty & ~flush);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

  fifo_mem #(
    .width (width),
    .depth (depth)
  ) u_mem (
    .clk     (clk),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (data_in),
    .raddr_i (rd_ptr_q),
    .rdata_o (rdata)
  );

  if (fwft == FIFO_FWFT) begin : g_fwft
    assign data_out = empty ? '0 : rdata;
  end else begin : g_std
    logic [width-1:0] dout_q;

    always_ff @(posedge clk or negedge rst) begin
      if (!rst)        dout_q <= '0;
      else if (rd_acc) dout_q <= rdata;
    end

    assign data_out = dout_q;
  end

endmodule

// File: doc/fifo_sync_prog.md
Name: fifo_sync_prog

Overview:
- Single-clock, parametrised FIFO; next generation of the team's FIFO family.
- Adds a selectable read mode (standard registered read or first-word-fall-through), an occupancy count, runtime almost-full/almost-empty thresholds, sticky overflow/underflow error flags, and a synchronous flush.
- Used as the local buffering stage between same-clock producer/consumer blocks, and as the reference model for the dual-clock FIFO's flag behaviour.

Parameters:
- width, 8, data word width in bits (>=1).
- depth, 8, number of entries; power of two, >=2. AW = clog2(depth).
- fwft, 0, read mode: 0 = standard (data_out registered on accepted rd), 1 = first-word-fall-through.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous clear of FIFO contents.
- wr  in  1  write request.
- data_in  in  width  write data, sampled with wr.
- rd  in  1  read request.
- data_out  out  width  read data.
- af_thresh  in  AW+1  almost-full threshold.
- ae_thresh  in  AW+1  almost-empty threshold.
- clr_err  in  1  clears the sticky error flags.
- full  out  1  count == depth.
- empty  out  1  count == 0.
- almost_full  out  1  count >= af_thresh.
- almost_empty  out  1  count <= ae_thresh.
- count  out  AW+1  current occupancy, 0..depth.
- overflow  out  1  sticky: a write was attempted while full.
- underflow  out  1  sticky: a read was attempted while empty.

Behaviour:
- Reset (rst low, asynchronous): wr_ptr=0, rd_ptr=0, count=0, data_out=0, overflow=0, underflow=0. Flags follow combinationally: empty=1, full=0. Memory contents are not reset.
- Pointers are AW bits and wrap depth-1 -> 0 naturally. count is a registered AW+1-bit counter.
- Acceptance uses pre-edge flags:
  - wr_acc = wr & ~full.
  - rd_acc = rd & ~empty.
- wr_acc: mem[wr_ptr] <= data_in; wr_ptr increments.
- rd_acc: rd_ptr increments.
- count update: +1 on wr_acc only, -1 on rd_acc only, unchanged when both or neither.
- Simultaneous rd and wr:
  - Neither full nor empty: both accepted; count unchanged.
  - When empty: write accepted, read rejected (underflow set).
  - When full: read accepted, write rejected (overflow set). No pass-through.
- Standard mode (fwft=0):
  - On rd_acc, data_out <= mem[rd_ptr]; the word is visible the cycle after the read edge (latency 1).
  - data_out holds its value otherwise, including on rejected reads.
- FWFT mode (fwft=1):
  - data_out = mem[rd_ptr] combinationally while empty=0, and 0 while empty=1.
  - A write into an empty FIFO makes the word visible on data_out in the cycle after the write edge.
  - rd_acc consumes the displayed word; the next word appears immediately after that edge.
- Flags full, empty, almost_full and almost_empty are combinational from registered count; there are no extra cycles of flag latency.
  - af_thresh=0 forces almost_full=1.
  - af_thresh > depth forces almost_full=0.
- overflow is set on wr & full; underflow is set on rd & empty. Both stay set until a clr_err cycle. If a set and clr_err occur in the same cycle, the set wins.
- flush: on the next edge, wr_ptr=rd_ptr=count=0.
  - flush has priority over wr and rd in the same cycle; those requests are discarded and do not set error flags.
  - data_out is unchanged in standard mode and reads 0 in FWFT mode.
  - overflow and underflow are not affected by flush.
- Threshold inputs may change at any time; the flags respond in the same cycle.

Decomposition:
- Shared package fifo_pkg:
  - ptr_w(depth) function returning clog2(depth).
  - Mode constants FIFO_STD=0 and FIFO_FWFT=1.
  - Shared with the dual-clock FIFO.
- One sub-module, fifo_mem: simple dual-port array, width x depth, with a synchronous write port and an asynchronous read port addressed by rd_ptr.
- The top level holds pointers, count, flags, error logic and the mode-dependent output stage.

Test Plan (width=8, depth=8, ae_thresh=1, af_thresh=6):
- Reset, then write 10, 20, 30:
  - count goes 1, 2, 3.
  - empty=0 after the first write edge.
  - almost_empty=1 until count=2.
- Standard mode, read 3 words:
  - data_out = 10, 20, 30, each one cycle after its rd edge.
  - empty=1 after the third read; count=0.
  - A fourth rd sets underflow=1 and data_out holds 30.
- Write 40, 50, 60, 70, 80, 90, 100, 120:
  - almost_full=1 at count=6; full=1 at count=8.
  - A 9th write (130) is rejected: overflow=1, count stays 8.
  - Draining returns 40..120 in order; 130 never appears.
- Full, with rd=wr=1 for one cycle: the read is accepted and the write dropped. count=7, overflow=1, full=0 next cycle.
- FWFT build, write 55 into the empty FIFO: data_out=55 the cycle after the write edge. A single rd then gives empty=1 and data_out=0.
- Flush and error clear:
  - With 5 entries, assert flush together with wr=1: next cycle count=0, empty=1, the write is discarded, overflow/underflow unchanged.
  - A clr_err pulse then clears both flags.
  - Asserting rst low mid-write clears count immediately, without waiting for a clock edge.
